// File: rtl/box_plotter.sv
// Rasterises one rectangle per request into a one-pixel-per-clock stream for a 160x120 VGA adapter.
// Optional build macro BOX_PLOTTER_CLIP_EN suppresses plots for off-screen pixels without changing timing.
module box_plotter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COL_W    = 3,
    parameter int SZ_W     = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter logic [COL_W-1:0] BG_COLOUR = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             erase,
    input  logic [X_W-1:0]   x0,
    input  logic [Y_W-1:0]   y0,
    input  logic [SZ_W-1:0]  w,
    input  logic [SZ_W-1:0]  h,
    input  logic [COL_W-1:0] colour_in,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [COL_W-1:0] colour,
    output logic             plot,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, PLOT, DONE} state_t;

    state_t           state_q, state_d;
    logic [X_W-1:0]   x0_q, x0_d;
    logic [Y_W-1:0]   y0_q, y0_d;
    logic [SZ_W-1:0]  w_q, w_d;
    logic [SZ_W-1:0]  h_q, h_d;
    logic [SZ_W-1:0]  dx_q, dx_d;
    logic [SZ_W-1:0]  dy_q, dy_d;
    logic [COL_W-1:0] col_q, col_d;

    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [COL_W-1:0] colour_q, colour_d;
    logic             plot_q, plot_d;
    logic             done_q, done_d;

    logic             busy_w;
    logic             accept;
    logic             last_col;
    logic             last_row;

    // The done cycle still counts as busy so a start can never land on it.
    assign busy_w   = (state_q != IDLE) || done_q;
    assign accept   = start && !busy_w;
    assign last_col = (dx_q == w_q - SZ_W'(1));
    assign last_row = (dy_q == h_q - SZ_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            col_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            col_q    <= col_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    x0_d  = x0;
                    y0_d  = y0;
                    w_d   = w;
                    h_d   = h;
                    dx_d  = '0;
                    dy_d  = '0;
                    col_d = erase ? BG_COLOUR : colour_in;
                    state_d = ((w == '0) || (h == '0)) ? DONE : PLOT;
                end
            end
            PLOT: begin
                if (last_col) begin
                    dx_d = '0;
                    if (last_row) begin
                        state_d = DONE;
                    end else begin
                        dy_d = dy_q + SZ_W'(1);
                    end
                end else begin
                    dx_d = dx_q + SZ_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef BOX_PLOTTER_CLIP_EN
    logic [X_W:0] sum_x;
    logic [Y_W:0] sum_y;
    logic         in_range;

    // Sums carry one extra bit so pixels past the screen edge are detected, not wrapped.
    assign sum_x    = (X_W+1)'(x0_q) + (X_W+1)'(dx_q);
    assign sum_y    = (Y_W+1)'(y0_q) + (Y_W+1)'(dy_q);
    assign in_range = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
`else
    logic [X_W-1:0] sum_x;
    logic [Y_W-1:0] sum_y;
    logic           in_range;

    assign sum_x    = x0_q + X_W'(dx_q);
    assign sum_y    = y0_q + Y_W'(dy_q);
    assign in_range = 1'b1;
`endif

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            PLOT: begin
                plot_d = in_range;
                if (in_range) begin
                    x_d      = sum_x[X_W-1:0];
                    y_d      = sum_y[Y_W-1:0];
                    colour_d = col_q;
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                plot_d = 1'b0;
            end
        endcase
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign done   = done_q;
    assign busy   = busy_w;

endmodule

// File: tb/tb_box_plotter.sv
// Randomised self-checking bench for box_plotter against a row-major pixel model.
module tb_box_plotter;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       erase;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [6:0] w;
    logic [6:0] h;
    logic [2:0] colour_in;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    box_plotter dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .erase     (erase),
        .x0        (x0),
        .y0        (y0),
        .w         (w),
        .h         (h),
        .colour_in (colour_in),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request and checks every cycle up to one past busy falling.
    // disturb_at > 0 re-pulses start with different fields after that cycle.
    task automatic drive_box(input string name, input int bx0, input int by0,
                             input int bw, input int bh, input int bcol,
                             input int be, input int disturb_at);
        int n;
        int i;
        int j;
        int ex;
        int ey;
        int ecol;
        int eplot;
        int edone;
        int ebusy;
        int lx;
        int ly;
        int lc;
        bit any;
        n    = bw * bh;
        ecol = be ? 0 : bcol;
        any  = 1'b0;
        lx = 0; ly = 0; lc = 0;
        @(negedge clk);
        x0 = 8'(bx0); y0 = 7'(by0); w = 7'(bw); h = 7'(bh);
        colour_in = 3'(bcol); erase = be[0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x0 = 8'($urandom); colour_in = 3'($urandom);
        n_cmp++;
        if (busy !== 1'b1 || plot !== 1'b0) begin
            n_err++;
            $display("FAIL %s accept: busy=%0b plot=%0b want busy=1 plot=0", name, busy, plot);
        end
        for (int t = 1; t <= n + 2; t++) begin
            @(posedge clk); #1;
            if (t == disturb_at) begin
                start = 1'b1; x0 = 8'd50; y0 = 7'($urandom); w = 7'd2; h = 7'd2;
                colour_in = 3'(~bcol); erase = ~be[0];
            end else if (t == disturb_at + 1) begin
                start = 1'b0; x0 = 8'($urandom); colour_in = 3'($urandom);
            end
            eplot = 0; ex = 0; ey = 0;
            if (t <= n) begin
                i = (t - 1) % bw;
                j = (t - 1) / bw;
`ifdef BOX_PLOTTER_CLIP_EN
                eplot = (bx0 + i < 160) && (by0 + j < 120);
                ex = bx0 + i;
                ey = by0 + j;
`else
                eplot = 1;
                ex = (bx0 + i) % 256;
                ey = (by0 + j) % 128;
`endif
                edone = 0; ebusy = 1;
            end else if (t == n + 1) begin
                edone = 1; ebusy = 1;
            end else begin
                edone = 0; ebusy = 0;
            end
            n_cmp++;
            if (plot !== eplot[0] || done !== edone[0] || busy !== ebusy[0]) begin
                n_err++;
                $display("FAIL %s ctrl t=%0d: plot/done/busy=%0b%0b%0b want %0b%0b%0b",
                         name, t, plot, done, busy, eplot[0], edone[0], ebusy[0]);
            end
            if (eplot != 0) begin
                n_cmp++;
                if (x !== 8'(ex) || y !== 7'(ey) || colour !== 3'(ecol)) begin
                    n_err++;
                    $display("FAIL %s pixel t=%0d: (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                             name, t, x, y, colour, ex, ey, ecol);
                end
                any = 1'b1; lx = ex; ly = ey; lc = ecol;
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle: plot/done/busy=%0b%0b%0b want 000", name, plot, done, busy);
        end
        if (any) begin
            n_cmp++;
            if (x !== 8'(lx) || y !== 7'(ly) || colour !== 3'(lc)) begin
                n_err++;
                $display("FAIL %s hold: (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                         name, x, y, colour, lx, ly, lc);
            end
        end
        $display("box %s x0=%0d y0=%0d w=%0d h=%0d erase=%0d done", name, bx0, by0, bw, bh, be);
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; erase = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; colour_in = '0;
        repeat (3) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({x, y, colour, plot, busy, done} !== '0) begin
                n_err++;
                $display("FAIL reset: x=%0d y=%0d c=%0d plot=%0b busy=%0b done=%0b want all 0",
                         x, y, colour, plot, busy, done);
            end
        end
        @(negedge clk);
        resetn = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic();
        drive_box("basic", 10, 20, 3, 2, 3'b110, 0, 0);
        drive_box("erase", 10, 20, 3, 2, 3'b111, 1, 0);
        drive_box("unit", 0, 0, 1, 1, 3'b011, 0, 0);
    endtask

    task automatic test_zero_size();
        drive_box("w0", 30, 40, 0, 5, 3'b101, 0, 0);
        drive_box("h0", 30, 40, 5, 0, 3'b101, 0, 0);
    endtask

    task automatic test_ignore_start();
        drive_box("ignore_mid", 20, 30, 4, 4, 3'b010, 0, 5);
        drive_box("ignore_done", 20, 30, 4, 4, 3'b001, 0, 17);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        x0 = 8'd20; y0 = 7'd30; w = 7'd4; h = 7'd4; colour_in = 3'b101; erase = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (plot !== 1'b1 || x !== 8'd20 || y !== 7'd31) begin
            n_err++;
            $display("FAIL rst_mid pixel5: plot=%0b (%0d,%0d) want plot=1 (20,31)", plot, x, y);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || x !== 8'd0) begin
            n_err++;
            $display("FAIL rst_mid drop: plot=%0b busy=%0b done=%0b x=%0d want 0 0 0 0",
                     plot, busy, done, x);
        end
        repeat (3) begin
            @(posedge clk); #1;
            n_cmp++;
            if (plot !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid held: plot=%0b busy=%0b want 0 0", plot, busy);
            end
        end
        @(negedge clk);
        resetn = 1'b1;
        $display("reset mid-box released");
        drive_box("after_rst", 5, 6, 4, 4, 3'b100, 0, 0);
    endtask

    task automatic test_edges();
        drive_box("corner", 158, 118, 4, 4, 3'b111, 0, 0);
        drive_box("wrap", 254, 126, 4, 4, 3'b011, 0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            drive_box("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                      int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_size();
        test_ignore_start();
        test_reset_mid();
        test_edges();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/box_plotter.md
Name: box_plotter

Overview:
- Pixel-stream engine directly downstream of the game control FSM.
- Control issues one draw or erase request per object (bird, wall segment) each frame. This block rasterises the request's rectangle into one pixel per clock for the 160x120 VGA adapter (x, y, colour, plot), then pulses done so control can advance to its next state.
- Erase paints the background colour.

Parameters:
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COL_W, 3, colour width.
- SZ_W, 7, box width/height field width (max 127).
- SCREEN_W, 160, visible columns.
- SCREEN_H, 120, visible rows.
- BG_COLOUR, 3'b000, colour used for erase requests.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request pulse, accepted only when busy=0
- erase  in  1  sampled with start; 1 = paint BG_COLOUR instead of colour_in
- x0  in  X_W  box origin column (top-left)
- y0  in  Y_W  box origin row
- w  in  SZ_W  box width in pixels
- h  in  SZ_W  box height in pixels
- colour_in  in  COL_W  fill colour
- x  out  X_W  pixel column to VGA adapter
- y  out  Y_W  pixel row
- colour  out  COL_W  pixel colour
- plot  out  1  write-enable for current x/y/colour
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset is asynchronous, active-low. While resetn=0, all outputs are 0 and the FSM is IDLE. A reset mid-operation aborts the box with no further plots.
- FSM states:
  - IDLE: busy=0, plot=0. On start=1, latch x0, y0, w, h, and colour (BG_COLOUR if erase=1, else colour_in). Clear offsets dx=dy=0.
    - If w=0 or h=0, go to DONE (zero plots).
    - Otherwise go to PLOT.
  - PLOT: busy=1. Each cycle present x=x0+dx, y=y0+dy, colour=latched, plot=1.
    - dx increments each cycle.
    - At dx=w-1: dx wraps to 0 and dy increments.
    - At dx=w-1 and dy=h-1: go to DONE.
  - DONE: busy=1, plot=0, done=1 for exactly one cycle, then IDLE.
- Outputs x, y, colour, plot and done are registered.
- Timing for start sampled at edge k:
  - First pixel is valid after edge k+1.
  - Last pixel is valid after edge k+w*h.
  - done=1 after edge k+w*h+1.
  - busy returns to 0 after edge k+w*h+2.
- Raster order is row-major: x inner, y outer.
- start while busy=1 is ignored and not queued. Input fields are don't-care except in the start cycle.
- Latched fields are immune to input changes during PLOT.
- Coordinate arithmetic: x0+dx is computed at X_W+1 bits and y0+dy at Y_W+1 bits. Clipping or wrap of out-of-range pixels is governed by the optional feature.
- x, y and colour hold their last values while plot=0.

Optional Feature:
- Macro: BOX_PLOTTER_CLIP_EN.
- With the macro defined:
  - Any pixel with x0+dx >= SCREEN_W or y0+dy >= SCREEN_H is scanned with plot=0.
  - The cycle count is unchanged (w*h), so done timing is independent of position.
  - Lets walls slide off the right edge cleanly.
- Without the macro:
  - No bounds check; plot=1 for every pixel.
  - x and y are truncated to X_W and Y_W bits (modulo wrap). Callers keep boxes on-screen.

Test Plan:
- Reset, then start with x0=10, y0=20, w=3, h=2, colour_in=3'b110, erase=0.
  - Exactly 6 plot cycles: (10,20), (11,20), (12,20), (10,21), (11,21), (12,21), all colour 3'b110.
  - done pulses 1 cycle after the last plot; busy low the cycle after.
- Same box with erase=1 and colour_in=3'b111 -> all 6 pixels have colour 3'b000.
- start with w=0, h=5 -> no plot; done pulses 2 cycles after start; busy high for 2 cycles.
- During a 4x4 box, pulse start again with new x0=50 and toggle x0/colour_in inputs -> second request ignored; all 16 pixels use the original latched values.
- Deassert resetn on the 5th pixel of a 4x4 box -> plot, busy and done drop to 0 immediately. A new start after release runs a full fresh box.
- CLIP_EN build, x0=158, y0=118, w=4, h=4 -> 16 scan cycles with only 4 plots: (158,118), (159,118), (158,119), (159,119); done at the same relative cycle as an unclipped 4x4.
  - Non-CLIP build: 16 plots, with x wrapping at 256 and y wrapping at 128.
